// File: rtl/mem_port_arbiter.sv
// Data-port arbiter for the shared I/D memory: single-beat core accesses and
// locked incrementing host bursts, with registered read-data return.
module mem_port_arbiter #(
    parameter int BURST_MAX = 16,
    parameter int FAIR      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c_req,
    input  logic                         c_we,
    input  logic [3:0]                   c_wmask,
    input  logic [31:0]                  c_addr,
    input  logic [31:0]                  c_wdata,
    output logic                         c_gnt,
    output logic                         c_rvalid,
    output logic [31:0]                  c_rdata,
    input  logic                         h_req,
    input  logic                         h_we,
    input  logic [3:0]                   h_wmask,
    input  logic [31:0]                  h_addr,
    input  logic [$clog2(BURST_MAX):0]   h_len,
    input  logic [31:0]                  h_wdata,
    output logic                         h_gnt,
    output logic                         h_rvalid,
    output logic [31:0]                  h_rdata,
    output logic                         h_done,
    output logic                         m_we,
    output logic [3:0]                   m_wmask,
    output logic [31:0]                  m_addr,
    output logic [31:0]                  m_wdata,
    input  logic [31:0]                  m_rdata
);
    localparam int LW = $clog2(BURST_MAX) + 1;

    typedef enum logic {IDLE, HBURST} state_t;

    state_t        state_q, state_d;
    logic          last_host_q, last_host_d;
    logic [LW-1:0] beats_left_q, beats_left_d;
    logic [31:0]   burst_addr_q, burst_addr_d;
    logic          burst_we_q, burst_we_d;
    logic [3:0]    burst_wmask_q, burst_wmask_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          h_rvalid_q, h_rvalid_d;
    logic [31:0]   c_rdata_q, c_rdata_d;
    logic [31:0]   h_rdata_q, h_rdata_d;

    logic          sel_c, sel_h;
    logic [LW-1:0] eff_len;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{c_addr[1:0], h_addr[1:0]};

    // Zero-length bursts count as one beat; oversized ones are clamped.
    always_comb begin
        if (h_len == '0)
            eff_len = LW'(1);
        else if (h_len > LW'(BURST_MAX))
            eff_len = LW'(BURST_MAX);
        else
            eff_len = h_len;
    end

    // Grants are gated by rst_n so every output is quiet while reset is held.
    always_comb begin
        sel_c = 1'b0;
        sel_h = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (c_req && h_req) begin
                if (FAIR != 0 && !last_host_q)
                    sel_h = 1'b1;
                else
                    sel_c = 1'b1;
            end else begin
                sel_c = c_req;
                sel_h = h_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_host_q   <= 1'b1;
            beats_left_q  <= '0;
            burst_addr_q  <= '0;
            burst_we_q    <= 1'b0;
            burst_wmask_q <= '0;
            c_rvalid_q    <= 1'b0;
            h_rvalid_q    <= 1'b0;
            c_rdata_q     <= '0;
            h_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_host_q   <= last_host_d;
            beats_left_q  <= beats_left_d;
            burst_addr_q  <= burst_addr_d;
            burst_we_q    <= burst_we_d;
            burst_wmask_q <= burst_wmask_d;
            c_rvalid_q    <= c_rvalid_d;
            h_rvalid_q    <= h_rvalid_d;
            c_rdata_q     <= c_rdata_d;
            h_rdata_q     <= h_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_host_d   = last_host_q;
        beats_left_d  = beats_left_q;
        burst_addr_d  = burst_addr_q;
        burst_we_d    = burst_we_q;
        burst_wmask_d = burst_wmask_q;
        case (state_q)
            IDLE: begin
                if (sel_c) begin
                    last_host_d = 1'b0;
                end else if (sel_h) begin
                    last_host_d = 1'b1;
                    if (eff_len > LW'(1)) begin
                        state_d       = HBURST;
                        beats_left_d  = eff_len - LW'(1);
                        burst_addr_d  = {h_addr[31:2], 2'b00} + 32'd4;
                        burst_we_d    = h_we;
                        burst_wmask_d = h_wmask;
                    end
                end
            end
            HBURST: begin
                beats_left_d = beats_left_q - LW'(1);
                burst_addr_d = burst_addr_q + 32'd4;
                if (beats_left_q == LW'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        c_rvalid_d = c_gnt && !m_we;
        h_rvalid_d = h_gnt && !m_we;
        c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
        h_rdata_d  = h_rvalid_d ? m_rdata : h_rdata_q;
    end

    always_comb begin
        c_gnt   = 1'b0;
        h_gnt   = 1'b0;
        h_done  = 1'b0;
        m_we    = 1'b0;
        m_wmask = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (sel_c) begin
            c_gnt   = 1'b1;
            m_we    = c_we;
            m_wmask = c_wmask;
            m_addr  = {c_addr[31:2], 2'b00};
            m_wdata = c_wdata;
        end else if (sel_h) begin
            h_gnt   = 1'b1;
            h_done  = (eff_len == LW'(1));
            m_we    = h_we;
            m_wmask = h_wmask;
            m_addr  = {h_addr[31:2], 2'b00};
            m_wdata = h_wdata;
        end else if (state_q == HBURST) begin
            h_gnt   = 1'b1;
            h_done  = (beats_left_q == LW'(1));
            m_we    = burst_we_q;
            m_wmask = burst_wmask_q;
            m_addr  = burst_addr_q;
            m_wdata = h_wdata;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign h_rvalid = h_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign h_rdata  = h_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench: a fair and a fixed-priority arbiter share one
// stimulus stream, each checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int BM = 16;
    localparam int LW = $clog2(BM) + 1;

    logic          clk, rst_n;
    logic          c_req, c_we, h_req, h_we;
    logic [3:0]    c_wmask, h_wmask;
    logic [31:0]   c_addr, c_wdata, h_addr, h_wdata;
    logic [LW-1:0] h_len;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int FI = (gi == 0) ? 1 : 0;
        logic        c_gnt, c_rvalid, h_gnt, h_rvalid, h_done, m_we;
        logic [31:0] c_rdata, h_rdata, m_addr, m_wdata, m_rdata;
        logic [3:0]  m_wmask;
        logic [31:0] mem  [256];
        logic [31:0] rmem [256];

        mem_port_arbiter #(.BURST_MAX(BM), .FAIR(FI)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .c_req(c_req), .c_we(c_we), .c_wmask(c_wmask), .c_addr(c_addr), .c_wdata(c_wdata),
            .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
            .h_req(h_req), .h_we(h_we), .h_wmask(h_wmask), .h_addr(h_addr), .h_len(h_len),
            .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_done(h_done),
            .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
        );

        // Memory seen by the DUT: async read, byte-masked write at the edge.
        assign m_rdata = mem[m_addr[9:2]];
        initial for (int k = 0; k < 256; k++) begin
            mem[k]  <= 32'(k) * 32'h9E37_79B1;
            rmem[k]  = 32'(k) * 32'h9E37_79B1;
        end
        always @(posedge clk)
            if (m_we)
                for (int b = 0; b < 4; b++)
                    if (m_wmask[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];

        // Reference: a host grant expands into the full list of beat addresses.
        logic [31:0] bq[$];
        logic        bwe, last_host, cur_c, cur_h;
        logic [3:0]  bmask, e_mask;
        logic        e_we, e_done, e_crv, e_hrv;
        logic [31:0] e_addr, e_wd, e_crd, e_hrd;
        string       pfx;
        initial pfx = $sformatf("fair%0d", FI);

        always @(negedge clk) begin
            if (!rst_n) begin
                bq.delete();
                last_host = 1'b1;
                cur_c = 1'b0; cur_h = 1'b0; e_we = 1'b0;
                e_crv = 1'b0; e_hrv = 1'b0; e_crd = '0; e_hrd = '0;
                chk({pfx, " rst c_gnt"}, c_gnt, 0);
                chk({pfx, " rst h_gnt"}, h_gnt, 0);
                chk({pfx, " rst h_done"}, h_done, 0);
                chk({pfx, " rst rvalid"}, {c_rvalid, h_rvalid}, 0);
                chk({pfx, " rst c_rdata"}, c_rdata, 0);
                chk({pfx, " rst h_rdata"}, h_rdata, 0);
                chk({pfx, " rst m_ctl"}, {m_we, m_wmask}, 0);
                chk({pfx, " rst m_addr"}, m_addr, 0);
                chk({pfx, " rst m_wdata"}, m_wdata, 0);
            end else begin
                cur_c = 1'b0; cur_h = 1'b0; e_done = 1'b0;
                e_we = 1'b0; e_mask = '0; e_addr = '0; e_wd = '0;
                if (bq.size() == 0) begin
                    if (h_req && (!c_req || (FI != 0 && !last_host))) begin
                        int L;
                        L = (h_len == 0) ? 1 : ((int'(h_len) > BM) ? BM : int'(h_len));
                        for (int k = 0; k < L; k++)
                            bq.push_back({h_addr[31:2], 2'b00} + 32'(4 * k));
                        bwe = h_we; bmask = h_wmask;
                    end else if (c_req) begin
                        cur_c = 1'b1; e_we = c_we; e_mask = c_wmask;
                        e_addr = {c_addr[31:2], 2'b00}; e_wd = c_wdata;
                    end
                end
                if (bq.size() > 0) begin
                    cur_h = 1'b1; e_addr = bq[0]; e_we = bwe; e_mask = bmask;
                    e_wd = h_wdata; e_done = (bq.size() == 1);
                end
                chk({pfx, " c_gnt"}, c_gnt, cur_c);
                chk({pfx, " h_gnt"}, h_gnt, cur_h);
                chk({pfx, " h_done"}, h_done, e_done);
                chk({pfx, " m_ctl"}, {m_we, m_wmask}, {e_we, e_mask});
                chk({pfx, " m_addr"}, m_addr, e_addr);
                chk({pfx, " m_wdata"}, m_wdata, e_wd);
                chk({pfx, " c_rvalid"}, c_rvalid, e_crv);
                chk({pfx, " h_rvalid"}, h_rvalid, e_hrv);
                chk({pfx, " c_rdata"}, c_rdata, e_crd);
                chk({pfx, " h_rdata"}, h_rdata, e_hrd);
            end
        end

        always @(posedge clk) begin
            if (rst_n) begin
                e_crv = cur_c && !e_we;
                e_hrv = cur_h && !e_we;
                if (e_crv) e_crd = rmem[e_addr[9:2]];
                if (e_hrv) e_hrd = rmem[e_addr[9:2]];
                if (e_we)
                    for (int b = 0; b < 4; b++)
                        if (e_mask[b]) rmem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
                if (cur_c) last_host = 1'b0;
                if (cur_h) begin
                    last_host = 1'b1;
                    void'(bq.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_wmask = 0; c_addr = 0; c_wdata = 0;
        h_req = 0; h_we = 0; h_wmask = 0; h_addr = 0; h_len = 0; h_wdata = 0;
    endtask

    task automatic host_burst(input logic we, input logic [31:0] addr, input logic [LW-1:0] len, input int beats);
        h_req = 1; h_we = we; h_wmask = 4'hF; h_addr = addr; h_len = len; h_wdata = $urandom;
        cyc();
        h_req = 0;
        repeat (beats) begin h_wdata = $urandom; cyc(); end
    endtask

    logic [3:0]  cg0, cg1;
    logic [31:0] rd[$];
    int          dones;

    initial begin
        rst_n = 0; idle();
        repeat (3) cyc();
        rst_n = 1;

        // Tie for 4 cycles: fair alternates starting with the core, fixed keeps the core.
        c_req = 1; h_req = 1; h_len = 1; c_addr = 32'h40; h_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cg0[k] = g_inst[0].c_gnt;
            cg1[k] = g_inst[1].c_gnt;
            cyc();
        end
        chk("fair tie sequence", {28'd0, cg0}, 32'h5);
        chk("fixed tie sequence", {28'd0, cg1}, 32'hF);

        idle(); c_req = 1; c_we = 1; c_wmask = 4'hF; c_addr = 32'h200; c_wdata = 32'hDEADBEEF;
        cyc();
        c_we = 0; cyc();
        idle();
        @(negedge clk);
        chk("core read rvalid", g_inst[0].c_rvalid, 1);
        chk("core read rdata", g_inst[0].c_rdata, 32'hDEADBEEF);
        cyc();

        idle(); h_req = 1; h_we = 1; h_wmask = 4'hF; h_addr = 32'h1000; h_len = 4; h_wdata = 1;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (g_inst[0].h_done) dones++;
            cyc();
            h_req = 0; h_wdata = 32'(k + 2);
        end
        chk("host write done count", dones, 1);
        idle(); h_req = 1; h_addr = 32'h1000; h_len = 4;
        cyc();
        idle();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (g_inst[0].h_rvalid) rd.push_back(g_inst[0].h_rdata);
            cyc();
        end
        chk("host read beats", rd.size(), 4);
        for (int k = 0; k < 4 && k < rd.size(); k++)
            chk($sformatf("host read word%0d", k), rd[k], 32'(k + 1));

        // Lockout: core holds its request through an 8-beat burst.
        idle(); h_req = 1; h_len = 8; h_addr = 32'h300;
        cyc();
        h_req = 0; c_req = 1; c_addr = 32'h40;
        repeat (9) cyc();
        idle();

        host_burst(1'b1, 32'h500, '0, 1);
        host_burst(1'b0, 32'h600, LW'(BM + 5), BM + 1);
        host_burst(1'b1, 32'hFFFF_FFF8, 4, 4);
        host_burst(1'b0, 32'hFFFF_FFF8, 4, 4);

        // Reset lands on the 3rd beat of an 8-beat burst.
        h_req = 1; h_we = 1; h_wmask = 4'hF; h_addr = 32'h700; h_len = 8;
        cyc(); h_req = 0; cyc();
        rst_n = 0; c_req = 1; h_req = 1; h_len = 1; h_addr = 32'h80;
        cyc(); cyc();
        rst_n = 1;
        @(negedge clk);
        chk("post-reset tie fair", g_inst[0].c_gnt, 1);
        chk("post-reset tie fixed", g_inst[1].c_gnt, 1);
        cyc();
        idle(); cyc();

        for (int n = 0; n < 3000; n++) begin
            c_req   = 1'($urandom_range(0, 1));
            c_we    = 1'($urandom_range(0, 1));
            c_wmask = 4'($urandom);
            c_addr  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : 32'h0)
                      | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            c_wdata = $urandom;
            h_req   = ($urandom_range(0, 3) == 0);
            h_we    = 1'($urandom_range(0, 1));
            h_wmask = 4'($urandom);
            h_addr  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : 32'h0)
                      | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            h_len   = LW'($urandom_range(0, BM + 7));
            h_wdata = $urandom;
            if ($urandom_range(0, 199) == 0) rst_n = 0;
            else rst_n = 1;
            cyc();
        end
        rst_n = 1; idle();
        repeat (BM + 3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the data port (port 2) of the shared dual-port instruction/data memory. It shares that single word-aligned port between two requesters: the core load/store unit (single-beat accesses) and a host/loader agent (locked incrementing bursts). The arbiter drives the memory data-port signals and returns registered read data with valid strobes. The instruction port (port 1) is not touched.

## Interface
- BURST_MAX, 16: maximum host burst length in words; power of two, at least 2.
- FAIR, 1: 1 selects round-robin between core and host; 0 selects fixed priority, core wins.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- c_req  in  1  core request, single beat.
- c_we  in  1  core write enable.
- c_wmask  in  4  core byte mask; bit i enables byte lane i.
- c_addr  in  32  core byte address; bits [1:0] are ignored.
- c_wdata  in  32  core write data.
- c_gnt  out  1  core access performed this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  32  core read data.
- h_req  in  1  host burst request.
- h_we  in  1  host burst write enable.
- h_wmask  in  4  host byte mask.
- h_addr  in  32  host burst base byte address.
- h_len  in  $clog2(BURST_MAX)+1  host burst length in words.
- h_wdata  in  32  host write data for the current beat.
- h_gnt  out  1  host beat performed this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  32  host read data.
- h_done  out  1  pulses on the final beat of a burst.
- m_we  out  1  memory write enable.
- m_wmask  out  4  memory byte mask.
- m_addr  out  32  memory byte address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; asynchronous read.

## Operation
- States:
  - IDLE: arbitrate a new access.
  - HBURST: host burst in progress.
- Registers:
  - last_gnt: which requester was granted last.
  - beats_left: remaining beats in the burst.
  - burst_addr, burst_we, burst_wmask: latched burst controls.
- IDLE arbitration:
  - Only one requester asserted: grant it.
  - Both asserted, FAIR=1: grant the requester not equal to last_gnt.
  - Both asserted, FAIR=0: grant the core.
- Core grant in IDLE:
  - m_* are driven from the c_* inputs.
  - c_gnt=1, last_gnt<=core.
  - State stays IDLE.
- Host grant in IDLE (first beat):
  - m_* are driven from the h_* inputs.
  - h_gnt=1, last_gnt<=host.
  - Effective length L: h_len if 1..BURST_MAX; h_len=0 counts as 1; h_len>BURST_MAX is clamped to BURST_MAX.
  - L=1: h_done=1 in this cycle; state stays IDLE.
  - L>1: latch burst_addr<=h_addr+4, burst_we, burst_wmask; beats_left<=L-1; go to HBURST.
- HBURST (one beat per cycle, no stalls):
  - m_addr=burst_addr, m_we=burst_we, m_wmask=burst_wmask, m_wdata=h_wdata.
  - h_gnt=1; burst_addr+=4 with 32-bit wrap, so 0xFFFFFFFC goes to 0x0.
  - beats_left decrements each beat.
  - When beats_left==1: h_done=1, go to IDLE.
  - c_req is ignored for the whole burst.
  - h_req and the h_* control inputs are ignored after the first beat.
  - The host must present the next beat's h_wdata in the cycle after each h_gnt.
- No grant: m_we=0, m_wmask=0, m_addr=0, m_wdata=0.
- Read return:
  - A granted read (we=0) captures m_rdata at the clock edge into c_rdata or h_rdata.
  - The matching rvalid is asserted for exactly one cycle.
  - rdata holds its value until the next capture.
- Writes complete in memory at the granting edge.

## Timing
- Reset values: all gnt, rvalid, done and m_* outputs 0; c_rdata=h_rdata=0; state IDLE; last_gnt=host (the core wins the first tie); beats_left=0.
- Reset asserted mid-burst: immediate return to IDLE. The burst is lost and no h_done is issued.
- gnt is combinational from req in IDLE (same cycle). In HBURST, h_gnt is registered state.
- Read latency: rvalid is 1 cycle after gnt.
- Back-to-back core reads give one grant per cycle.
- Burst of L beats: L consecutive h_gnt cycles. The core is blocked for L cycles, and its first grant can occur in the cycle after h_done.
- Same-address write then read by the other requester in the next cycle returns the new data.

## Test plan
- Core single read and write:
  - Core writes 0xDEADBEEF to 0x200 with mask 0xF.
  - Next cycle, core reads 0x200.
  - Required: c_gnt in both cycles; c_rvalid one cycle after the read; c_rdata=0xDEADBEEF.
- Host 4-word write then read:
  - Host writes 4 words from 0x1000 with data 1,2,3,4, then bursts a read of the same 4 words.
  - Required: h_gnt high 4 cycles each; m_addr 0x1000..0x100C; h_done on the 4th beat; h_rvalid data 1,2,3,4.
- Contention:
  - FAIR=1, c_req and h_req (len 1) held high for 4 cycles after reset.
  - Required: grants core, host, core, host.
  - Repeat with FAIR=0: the core is granted all 4 cycles.
- Burst lockout:
  - Host 8-beat burst while c_req is held high.
  - Required: c_gnt=0 for 8 cycles; c_gnt=1 in the cycle after h_done.
- Edge lengths and wrap:
  - h_len=0 gives 1 beat with h_done.
  - h_len=BURST_MAX+5 gives BURST_MAX beats.
  - Base 0xFFFFFFF8 with len 4 gives m_addr FFFFFFF8, FFFFFFFC, 0, 4.
- Reset mid-burst:
  - Assert rst_n=0 on the 3rd beat of an 8-beat burst.
  - Required: all outputs 0 immediately; after release, IDLE with no h_done; a tie is granted to the core.
